// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue in front of the register file write port.
// Drains one entry per cycle and forwards the youngest queued value to two read ports.
module regfile_writeback_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain_en,
    output logic              wen,
    output logic [ADDR_W-1:0] write_Rd,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] fwd_Ra,
    input  logic [ADDR_W-1:0] fwd_Rb,
    output logic              fwd_hit_a,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data_b,
    output logic [ADDR_W:0]   pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push, pop, not_empty;
    logic hit_a, hit_b;
    logic [DATA_W-1:0] dat_a, dat_b;

    assign not_empty = (count_q != '0);
    assign in_ready  = rst_n && (count_q != CNT_W'(DEPTH));
    // Register 0 is hardwired zero: the request handshakes but never occupies an entry.
    assign push      = in_valid && in_ready && (in_rd != '0);
    assign wen       = rst_n && drain_en && not_empty;
    assign pop       = wen;

    assign write_Rd   = (rst_n && not_empty) ? rd_q[head_q]   : '0;
    assign write_data = (rst_n && not_empty) ? data_q[head_q] : '0;
    assign pending    = count_q;

    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is never reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_q]   <= in_rd;
            data_q[tail_q] <= in_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest pending write.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx   = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        dat_a = '0;
        dat_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((fwd_Ra != '0) && (rd_q[idx] == fwd_Ra)) begin
                    hit_a = 1'b1;
                    dat_a = data_q[idx];
                end
                if ((fwd_Rb != '0) && (rd_q[idx] == fwd_Rb)) begin
                    hit_b = 1'b1;
                    dat_b = data_q[idx];
                end
            end
        end
    end

    assign fwd_hit_a  = rst_n && hit_a;
    assign fwd_data_a = (rst_n && hit_a) ? dat_a : '0;
    assign fwd_hit_b  = rst_n && hit_b;
    assign fwd_data_b = (rst_n && hit_b) ? dat_b : '0;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based reference model.
module tb_regfile_writeback_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_data;
    logic              drain_en;
    logic              wen;
    logic [ADDR_W-1:0] write_Rd;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] fwd_Ra;
    logic [ADDR_W-1:0] fwd_Rb;
    logic              fwd_hit_a;
    logic [DATA_W-1:0] fwd_data_a;
    logic              fwd_hit_b;
    logic [DATA_W-1:0] fwd_data_b;
    logic [ADDR_W:0]   pending;

    regfile_writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .drain_en(drain_en), .wen(wen), .write_Rd(write_Rd), .write_data(write_data),
        .fwd_Ra(fwd_Ra), .fwd_Rb(fwd_Rb),
        .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
        .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
        .pending(pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the queue contents in acceptance order.
    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] d;
    } ent_t;
    ent_t mq[$];

    task automatic model_edge();
        bit rdy, w;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
        end else begin
            rdy = (mq.size() != DEPTH);
            w   = drain_en && (mq.size() != 0);
            if (w) void'(mq.pop_front());
            if (in_valid && rdy && in_rd != 0) begin
                e.rd = in_rd;
                e.d  = in_data;
                mq.push_back(e);
            end
        end
    endtask

    task automatic model_fwd(input logic [ADDR_W-1:0] a, output bit hit, output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (rst_n && a != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].rd == a) begin
                    hit = 1'b1;
                    d   = mq[i].d;
                    break;
                end
            end
        end
    endtask

    task automatic model_check(input string tag);
        bit hb_a, hb_b;
        logic [DATA_W-1:0] db_a, db_b;
        bit ne;
        ne = rst_n && (mq.size() != 0);
        model_fwd(fwd_Ra, hb_a, db_a);
        model_fwd(fwd_Rb, hb_b, db_b);
        chk({tag, ".in_ready"},   in_ready,   rst_n && (mq.size() != DEPTH));
        chk({tag, ".wen"},        wen,        ne && drain_en);
        chk({tag, ".write_Rd"},   write_Rd,   ne ? mq[0].rd : '0);
        chk({tag, ".write_data"}, write_data, ne ? mq[0].d  : '0);
        chk({tag, ".fwd_hit_a"},  fwd_hit_a,  hb_a);
        chk({tag, ".fwd_data_a"}, fwd_data_a, db_a);
        chk({tag, ".fwd_hit_b"},  fwd_hit_b,  hb_b);
        chk({tag, ".fwd_data_b"}, fwd_data_b, db_b);
        chk({tag, ".pending"},    pending,    mq.size());
    endtask

    task automatic run_cycle(input string tag, input bit r, input bit v, input logic [ADDR_W-1:0] rd,
                             input logic [DATA_W-1:0] d, input bit dr,
                             input logic [ADDR_W-1:0] fa, input logic [ADDR_W-1:0] fb);
        rst_n = r; in_valid = v; in_rd = rd; in_data = d; drain_en = dr; fwd_Ra = fa; fwd_Rb = fb;
        #1;
        model_check(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        bit                rst;
        bit                vld;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] d;
        bit                dr;
        logic [ADDR_W-1:0] fa;
        logic [ADDR_W-1:0] fb;
        bit                rdy;
        bit                wen;
        logic [ADDR_W-1:0] wrd;
        logic [DATA_W-1:0] wd;
        bit                ha;
        logic [DATA_W-1:0] da;
        bit                hb;
        logic [DATA_W-1:0] db;
        logic [ADDR_W:0]   pend;
    } vec_t;

    vec_t vec[18];

    initial begin
        //            rst vld rd  data          dr fa fb  rdy wen wrd wdata         ha da            hb db            pend
        vec[0]  = '{0, 1, 3, 32'h0000AAAA, 1, 3, 3,  0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0};
        vec[1]  = '{0, 1, 3, 32'h0000AAAA, 1, 3, 3,  0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0};
        vec[2]  = '{1, 0, 3, 32'h0,        1, 3, 3,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0};
        vec[3]  = '{1, 1, 5, 32'hDEADBEEF, 1, 5, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0};
        vec[4]  = '{1, 0, 0, 32'h0,        1, 5, 5,  1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1};
        vec[5]  = '{1, 0, 0, 32'h0,        1, 5, 5,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0};
        vec[6]  = '{1, 1, 2, 32'h11,       0, 2, 7,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0};
        vec[7]  = '{1, 1, 7, 32'h22,       0, 2, 7,  1, 0, 2, 32'h11,       1, 32'h11,       0, 32'h0,        1};
        vec[8]  = '{1, 1, 2, 32'h33,       0, 2, 7,  1, 0, 2, 32'h11,       1, 32'h11,       1, 32'h22,       2};
        vec[9]  = '{1, 1, 9, 32'h44,       0, 2, 7,  1, 0, 2, 32'h11,       1, 32'h33,       1, 32'h22,       3};
        vec[10] = '{1, 1, 4, 32'h55,       0, 2, 7,  0, 0, 2, 32'h11,       1, 32'h33,       1, 32'h22,       4};
        vec[11] = '{1, 0, 0, 32'h0,        1, 2, 7,  0, 1, 2, 32'h11,       1, 32'h33,       1, 32'h22,       4};
        vec[12] = '{1, 0, 0, 32'h0,        1, 2, 7,  1, 1, 7, 32'h22,       1, 32'h33,       1, 32'h22,       3};
        vec[13] = '{1, 0, 0, 32'h0,        1, 2, 7,  1, 1, 2, 32'h33,       1, 32'h33,       0, 32'h0,        2};
        vec[14] = '{1, 0, 0, 32'h0,        1, 2, 7,  1, 1, 9, 32'h44,       0, 32'h0,        0, 32'h0,        1};
        vec[15] = '{1, 0, 0, 32'h0,        1, 2, 7,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0};
        vec[16] = '{1, 1, 0, 32'hFFFFFFFF, 1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0};
        vec[17] = '{1, 0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0};

        rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0; drain_en = 1'b0;
        fwd_Ra = '0; fwd_Rb = '0;
        @(posedge clk);
        model_edge();
        #1;

        for (int i = 0; i < 18; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            rst_n = vec[i].rst; in_valid = vec[i].vld; in_rd = vec[i].rd; in_data = vec[i].d;
            drain_en = vec[i].dr; fwd_Ra = vec[i].fa; fwd_Rb = vec[i].fb;
            #1;
            chk({t, ".in_ready"},   in_ready,   vec[i].rdy);
            chk({t, ".wen"},        wen,        vec[i].wen);
            chk({t, ".write_Rd"},   write_Rd,   vec[i].wrd);
            chk({t, ".write_data"}, write_data, vec[i].wd);
            chk({t, ".fwd_hit_a"},  fwd_hit_a,  vec[i].ha);
            chk({t, ".fwd_data_a"}, fwd_data_a, vec[i].da);
            chk({t, ".fwd_hit_b"},  fwd_hit_b,  vec[i].hb);
            chk({t, ".fwd_data_b"}, fwd_data_b, vec[i].db);
            chk({t, ".pending"},    pending,    vec[i].pend);
            @(posedge clk);
            model_edge();
            #1;
        end

        // Full queue with a pop pending: no accept that cycle, then push+pop together.
        for (int i = 0; i < DEPTH; i++)
            run_cycle("fill", 1, 1, ADDR_W'(i + 1), 32'h100 + i, 0, 1, 2);
        chk("full.pending", pending, DEPTH);
        rst_n = 1; in_valid = 1; in_rd = 6; in_data = 32'h600; drain_en = 1;
        #1;
        chk("full.in_ready", in_ready, 0);
        chk("full.wen", wen, 1);
        @(posedge clk);
        model_edge();
        #1;
        chk("full.pending_after", pending, DEPTH - 1);
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            run_cycle("wrap", 1, 1, ADDR_W'(10 + (i % 5)), 32'hA000 + i, 1, 11, 12);
            chk("wrap.pending", pending, DEPTH - 1);
        end
        for (int i = 0; i < DEPTH; i++)
            run_cycle("wrapdrain", 1, 0, 0, 0, 1, 11, 12);
        chk("wrapdrain.pending", pending, 0);

        // Reset in the middle of a drain discards everything still queued.
        for (int i = 0; i < 3; i++)
            run_cycle("pre_rst", 1, 1, ADDR_W'(3 + i), 32'hB0 + i, 0, 3, 5);
        run_cycle("mid_drain", 1, 0, 0, 0, 1, 4, 5);
        run_cycle("rst_pulse", 0, 1, 8, 32'hBAD, 1, 4, 5);
        rst_n = 1; in_valid = 0; drain_en = 1; fwd_Ra = 4; fwd_Rb = 5;
        #1;
        chk("post_rst.wen", wen, 0);
        chk("post_rst.pending", pending, 0);
        chk("post_rst.hit_a", fwd_hit_a, 0);
        chk("post_rst.hit_b", fwd_hit_b, 0);
        @(posedge clk);
        model_edge();
        #1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            run_cycle("rand", $urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                      ADDR_W'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) != 0,
                      ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
